uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the number of data bits per frame (legal 5..8).
REQ-002 Parameter SB_TICKS, default 16, SHALL set the stop-bit length in s_tick periods (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Port clock  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port s_tick  input  1  SHALL be a one-clock-wide enable pulse at 16x the baud rate, from the baud rate generator.
REQ-006 Port rx  input  1  SHALL be the asynchronous serial line; idle high, LSB first.
REQ-007 Port rx_data  output  DATA_BITS  SHALL hold the last accepted received word.
REQ-008 Port rx_valid  output  1  SHALL be high while rx_data holds an unconsumed word.
REQ-009 Port rx_ready  input  1  SHALL indicate the consumer takes rx_data when rx_valid is also high.
REQ-010 Port frame_err  output  1  SHALL pulse high for exactly one clock when a stop bit samples low.
REQ-011 Port overrun  output  1  SHALL be a sticky flag set when a good frame is lost because rx_valid was still pending.
REQ-012 Port busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_sync); all FSM decisions SHALL use rx_sync only.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK; the tick counter s is 4 bits wide (5 bits if SB_TICKS > 16), and the bit counter n is 3 bits wide.
REQ-015 In IDLE, rx_sync == 0 SHALL cause a move to START with s cleared; s_tick is not required for this move.
REQ-016 In START, on s_tick with s == 7: if rx_sync == 0, the FSM SHALL go to DATA with s = 0 and n = 0; otherwise it SHALL return to IDLE (glitch rejected) and produce no outputs.
REQ-017 In START, on any other s_tick, s SHALL increment by 1.
REQ-018 In DATA, on s_tick with s == 15, the FSM SHALL shift rx_sync into the MSB of a shift register (right shift) and clear s.
REQ-019 In DATA, on that same s_tick, the FSM SHALL go to STOP if n == DATA_BITS-1, otherwise n increments.
REQ-020 In DATA, other s_ticks SHALL increment s.
REQ-021 In STOP, on s_tick with s == SB_TICKS-1, rx_sync SHALL be sampled as the stop bit; other s_ticks SHALL increment s.
REQ-022 Stop bit == 1: the word SHALL be delivered per REQ-025..027 and the FSM SHALL return to IDLE.
REQ-023 Stop bit == 0: frame_err SHALL pulse, the word SHALL be discarded, and the FSM SHALL enter BREAK.
REQ-024 BREAK SHALL hold until rx_sync == 1, then go to IDLE, so a line held low yields exactly one frame_err.
REQ-025 Delivery with rx_valid == 0, or with rx_valid && rx_ready in the same cycle: rx_data SHALL load the word and rx_valid SHALL be 1 on the next clock.
REQ-026 Delivery with rx_valid == 1 and rx_ready == 0: the new word SHALL be dropped, rx_data SHALL be unchanged and overrun SHALL set.
REQ-027 rx_valid && rx_ready with no delivery SHALL clear rx_valid on the next clock; rx_data SHALL hold its value.
REQ-028 With fewer than DATA_BITS data bits, the received word SHALL be right-aligned (LSB at bit 0) and the upper bits zero.
REQ-029 s_tick arriving in IDLE or BREAK SHALL have no effect; the counters SHALL only advance on s_tick.
REQ-030 Latency from the stop-bit sampling tick to rx_valid high SHALL be 1 clock.

Reset
REQ-031 Reset SHALL force the FSM to IDLE and clear s, n, the shift register, rx_data, rx_valid, frame_err, overrun and busy.
REQ-032 Reset SHALL set both synchronizer flops to 1 (idle line).
REQ-033 Reset asserted mid-frame SHALL abort the frame with no delivery and no frame_err.
REQ-034 overrun SHALL clear only on reset.

Verification
REQ-035 Bench SHALL cover: 8N1 frame 0xA5 with s_tick every 10 clocks and rx_ready=0 -> rx_data=0xA5, rx_valid=1, frame_err=0, busy low after stop.
REQ-036 Bench SHALL cover: rx low pulse of 5 ticks in IDLE -> return to IDLE, rx_valid stays 0, no frame_err.
REQ-037 Bench SHALL cover: frame 0x3C with stop bit low, then rx held low 40 ticks -> one frame_err pulse, rx_valid=0, busy until rx returns high.
REQ-038 Bench SHALL cover: frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, overrun=1; then rx_ready=1 for 1 clock -> rx_valid=0.
REQ-039 Bench SHALL cover: rx_ready asserted in the same cycle a second frame (0x55) delivers -> rx_data=0x55, rx_valid=1, overrun=0.
REQ-040 Bench SHALL cover: reset pulsed after 4 data bits of 0xF0 -> all outputs 0, busy=0, and the next clean frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, configurable data/stop length.
// Holds one received word behind a valid/ready handshake.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int SW = (SB_TICKS > 16) ? 5 : 4;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
  localparam logic [2:0]    N_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state;
  logic [SW-1:0]        s;
  logic [2:0]           n;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 stop_hit;
  logic                 good;

  assign stop_hit = (state == STOP) && s_tick && (s == S_STOP);
  assign good     = stop_hit && rx_sync;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              // mid start bit: a high line here was only a glitch
              if (!rx_sync) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
              s     <= '0;
              if (n == N_LAST) state <= STOP;
              else             n     <= n + 3'd1;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              if (rx_sync) begin
                state <= IDLE;
              end else begin
                state     <= BREAK;
                frame_err <= 1'b1;
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end
        BREAK: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (good && (!rx_valid || rx_ready)) begin
      rx_data  <= shreg;
      rx_valid <= 1'b1;
    end else if (good) begin
      overrun  <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed corner cases, a vector table,
// and random frames against a frame-level reference model.
module tb_uart_rx;

  localparam int DIV  = 10;
  localparam int BITC = 16 * DIV;
  localparam int DELIVER_TICK = 8 + 16 * 8 + 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int start_p = 0;
  int ftick = 0;
  int div = 0;
  int fe_seen = 0;
  bit track = 0;
  bit rdy_deliver = 0;
  bit lat_check = 0;
  bit ready_lvl = 0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       consume;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_ov;
    int         e_fe;
  } vec_t;

  vec_t tbl [6];

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_tick   (s_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, then step to the next falling edge.
  task automatic cyc();
    bit is_del;
    s_tick = (div == DIV - 1);
    div = (div == DIV - 1) ? 0 : div + 1;
    is_del = 1'b0;
    if (track && s_tick && cyc_n > start_p + 2) begin
      ftick++;
      is_del = (ftick == DELIVER_TICK);
    end
    rx_ready = ready_lvl | (rdy_deliver & is_del);
    if (lat_check && is_del) chk("pre_valid", rx_valid, 0);
    @(negedge clock);
    cyc_n++;
    if (frame_err) fe_seen++;
    if (lat_check && is_del) begin
      chk("lat_valid", rx_valid, 1);
      chk("lat_busy", busy, 0);
    end
  endtask

  task automatic idle(input int ticks);
    rx = 1'b1;
    repeat (ticks * DIV) cyc();
  endtask

  task automatic pulse_ready();
    ready_lvl = 1'b1;
    cyc();
    ready_lvl = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input bit rdy_del);
    rdy_deliver = rdy_del;
    start_p = cyc_n;
    ftick = 0;
    track = 1'b1;
    rx = 1'b0;
    repeat (BITC) cyc();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BITC) cyc();
    end
    rx = stop;
    repeat (BITC) cyc();
    rx = 1'b1;
    track = 1'b0;
    rdy_deliver = 1'b0;
  endtask

  initial begin
    logic [7:0] data_m;
    logic       valid_m;
    logic       ov_m;
    int         fe_m;
    logic [7:0] d;
    logic       ok;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1};
    tbl[3] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1};

    do_reset();
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);

    // 8N1 0xA5 with rx_ready low
    fe_seen = 0;
    idle(3);
    lat_check = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    lat_check = 1'b0;
    idle(3);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_valid", rx_valid, 1);
    chk("a5_ferr", fe_seen, 0);
    chk("a5_busy", busy, 0);

    // start-bit glitch of 5 ticks
    pulse_ready();
    chk("gl_pre_valid", rx_valid, 0);
    rx = 1'b0;
    repeat (5 * DIV) cyc();
    chk("gl_busy_hi", busy, 1);
    idle(12);
    chk("gl_valid", rx_valid, 0);
    chk("gl_ferr", fe_seen, 0);
    chk("gl_busy", busy, 0);
    chk("gl_data", rx_data, 8'hA5);

    // bad stop then line held low
    fe_seen = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40 * DIV) cyc();
    chk("brk_ferr", fe_seen, 1);
    chk("brk_valid", rx_valid, 0);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    repeat (4) cyc();
    chk("brk_idle", busy, 0);
    chk("brk_data", rx_data, 8'hA5);
    chk("brk_ferr2", fe_seen, 1);

    // overrun
    idle(3);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(3);
    chk("ov_data", rx_data, 8'h11);
    chk("ov_flag", overrun, 1);
    chk("ov_valid", rx_valid, 1);
    pulse_ready();
    chk("ov_consumed", rx_valid, 0);
    chk("ov_hold", rx_data, 8'h11);
    chk("ov_sticky", overrun, 1);

    // ready in the delivery cycle
    do_reset();
    chk("rst_ov_clr", overrun, 0);
    idle(3);
    send_frame(8'h33, 1'b1, 1'b0);
    idle(3);
    chk("sc_first", rx_data, 8'h33);
    send_frame(8'h55, 1'b1, 1'b1);
    idle(3);
    chk("sc_data", rx_data, 8'h55);
    chk("sc_valid", rx_valid, 1);
    chk("sc_ovr", overrun, 0);

    // reset mid-frame
    fe_seen = 0;
    rx = 1'b0;
    repeat (BITC) cyc();
    repeat (4 * BITC) cyc();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    rx = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("mid_data", rx_data, 0);
    chk("mid_valid", rx_valid, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_ferr", fe_seen, 0);
    chk("mid_idle", busy, 0);
    idle(3);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(3);
    chk("mid_next", rx_data, 8'h0F);
    chk("mid_nvalid", rx_valid, 1);
    chk("mid_nferr", fe_seen, 0);

    // vector table
    do_reset();
    fe_seen = 0;
    idle(3);
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].consume) pulse_ready();
      send_frame(tbl[i].d, tbl[i].stop, 1'b0);
      idle(3);
      chk($sformatf("tbl%0d_data", i), rx_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_valid", i), rx_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].e_ov);
      chk($sformatf("tbl%0d_ferr", i), fe_seen, tbl[i].e_fe);
    end

    // random frames against the frame-level model
    do_reset();
    fe_seen = 0;
    data_m = 8'h00;
    valid_m = 1'b0;
    ov_m = 1'b0;
    fe_m = 0;
    idle(3);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready();
        valid_m = 1'b0;
      end
      d = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(d, ok, 1'b0);
      if (ok) begin
        if (!valid_m) begin
          valid_m = 1'b1;
          data_m = d;
        end else begin
          ov_m = 1'b1;
        end
      end else begin
        fe_m++;
      end
      idle(int'($urandom_range(2, 5)));
      chk($sformatf("rnd%0d_data", i), rx_data, data_m);
      chk($sformatf("rnd%0d_valid", i), rx_valid, valid_m);
      chk($sformatf("rnd%0d_ovr", i), overrun, ov_m);
      chk($sformatf("rnd%0d_ferr", i), fe_seen, fe_m);
      chk($sformatf("rnd%0d_busy", i), busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
